// File: rtl/keynsham_irq_arbiter_pkg.sv
// keynsham_irq_arbiter_pkg: register offsets and CLAIM word layout shared by RTL, bench and software tests
package keynsham_irq_arbiter_pkg;
   localparam logic [1:0] REG_STATUS = 2'd0;
   localparam logic [1:0] REG_ENABLE = 2'd1;
   localparam logic [1:0] REG_CLAIM  = 2'd2;
   localparam logic [1:0] REG_EOI    = 2'd3;
   localparam int CLAIM_VALID_BIT = 31;

   function automatic logic [31:0] claim_word(input logic valid, input logic [4:0] id);
      return valid ? ((32'd1 << CLAIM_VALID_BIT) | 32'(id)) : 32'd0;
   endfunction
endpackage

// File: rtl/keynsham_rr_pick.sv
// keynsham_rr_pick: picks the first set request at or above ptr, wrapping at nr_sources
module keynsham_rr_pick #(
   parameter int nr_sources = 4,
   localparam int pw = $clog2(nr_sources)
) (
   input  logic [nr_sources-1:0] req,
   input  logic [pw-1:0]         ptr,
   output logic                  valid,
   output logic [4:0]            id
);
   logic [2*nr_sources-1:0] dbl;
   logic [nr_sources-1:0]   rot;
   logic [pw-1:0]           off, sel;

   // rotate so ptr lands on bit 0, then a plain lowest-set search; the sum wraps because nr_sources is a power of two
   always_comb begin
      dbl = {req, req} >> ptr;
      rot = dbl[nr_sources-1:0];
      off = '0;
      for (int i = nr_sources - 1; i >= 0; i--)
         if (rot[i]) off = pw'(i);
      sel = off + ptr;
      valid = |req;
      id = 5'(sel);
   end
endmodule

// File: rtl/keynsham_irq_arbiter.sv
// keynsham_irq_arbiter: edge-capturing interrupt arbiter on the Keynsham bus.
// KEYNSHAM_IRQ_ARB_ROUND_ROBIN_EN selects a rotating claim pointer; otherwise lowest index wins.
module keynsham_irq_arbiter
   import keynsham_irq_arbiter_pkg::*;
#(
   parameter logic [31:0] bus_address = 32'h0,
   parameter logic [31:0] bus_size    = 32'h0,
   parameter int          nr_sources  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  bus_access,
   output logic                  bus_cs,
   input  logic [29:0]           bus_addr,
   input  logic [31:0]           bus_wr_val,
   input  logic                  bus_wr_en,
   input  logic [3:0]            bus_bytesel,
   output logic                  bus_error,
   output logic                  bus_ack,
   output logic [31:0]           bus_data,
   input  logic [nr_sources-1:0] irq_src,
   output logic                  irq_out
);
   localparam int pw = $clog2(nr_sources);

   logic [nr_sources-1:0] pending, enable, prev, masked, rise, clr, lane, pick_hot;
   logic [pw-1:0]         ptr;
   logic                  valid, acc, wr_err, claim, eoi, en_wr, unused_bits;
   logic [4:0]            id;
   logic [1:0]            sel;
   logic [31:0]           rdata;

   // bus_size of 0 makes the mask zero, so the block then answers every address
   assign bus_cs = ((({bus_addr, 2'b00} ^ bus_address) & ~(bus_size - 32'd1)) == 32'd0);
   assign sel = bus_addr[1:0];
   assign acc = bus_access & bus_cs;
   assign masked = pending & enable;
   assign irq_out = |masked;
   assign rise = irq_src & ~prev;
   assign unused_bits = ^{bus_wr_val, bus_bytesel};

   keynsham_rr_pick #(.nr_sources(nr_sources)) u_pick (
      .req  (masked),
      .ptr  (ptr),
      .valid(valid),
      .id   (id)
   );

   always_comb begin
      wr_err = acc & bus_wr_en & (sel == REG_STATUS || sel == REG_CLAIM);
      claim = acc & ~bus_wr_en & (sel == REG_CLAIM) & valid;
      eoi = acc & bus_wr_en & (sel == REG_EOI);
      en_wr = acc & bus_wr_en & (sel == REG_ENABLE);
      pick_hot = claim ? ({{(nr_sources-1){1'b0}}, 1'b1} << id) : '0;
      clr = pick_hot | (eoi ? bus_wr_val[nr_sources-1:0] : '0);
      for (int i = 0; i < nr_sources; i++) lane[i] = bus_bytesel[i/8];
      rdata = (sel == REG_STATUS) ? 32'(pending) :
              (sel == REG_ENABLE) ? 32'(enable) :
              (sel == REG_CLAIM)  ? claim_word(valid, id) : 32'd0;
   end

   // rising edges are OR'd in after the clear so a simultaneous set wins
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pending   <= '0;
         enable    <= '0;
         prev      <= '0;
         bus_ack   <= 1'b0;
         bus_error <= 1'b0;
         bus_data  <= '0;
      end else begin
         prev      <= irq_src;
         pending   <= (pending & ~clr) | rise;
         enable    <= en_wr ? ((enable & ~lane) | (bus_wr_val[nr_sources-1:0] & lane)) : enable;
         bus_ack   <= acc;
         bus_error <= wr_err;
         bus_data  <= (acc & ~bus_wr_en) ? rdata : '0;
      end
   end

`ifdef KEYNSHAM_IRQ_ARB_ROUND_ROBIN_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) ptr <= '0;
      else if (claim) ptr <= pw'(id) + pw'(1);
   end
`else
   assign ptr = '0;
`endif
endmodule

// File: tb/tb_keynsham_irq_arbiter.sv
// tb_keynsham_irq_arbiter: directed scenarios plus random traffic against a behavioural model
module tb_keynsham_irq_arbiter;
   import keynsham_irq_arbiter_pkg::*;
   localparam int N = 4;

   logic clk, rst, bus_access, bus_wr_en, bus_cs, bus_error, bus_ack, irq_out;
   logic [29:0] bus_addr;
   logic [31:0] bus_wr_val, bus_data;
   logic [3:0] bus_bytesel;
   logic [N-1:0] irq_src;
   int n_checks = 0;
   int n_fail = 0;

   keynsham_irq_arbiter #(.nr_sources(N)) dut (
      .clk(clk), .rst(rst), .bus_access(bus_access), .bus_cs(bus_cs), .bus_addr(bus_addr),
      .bus_wr_val(bus_wr_val), .bus_wr_en(bus_wr_en), .bus_bytesel(bus_bytesel),
      .bus_error(bus_error), .bus_ack(bus_ack), .bus_data(bus_data),
      .irq_src(irq_src), .irq_out(irq_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // behavioural model: state updated at the clock, next values from the register rules
   logic [N-1:0] m_pend, m_en, m_prev, n_pend, n_en;
   int m_ptr, n_ptr, cid;
   logic m_ack, m_err, n_ack, n_err;
   logic [31:0] m_data, n_data;

   always_comb begin
      cid = -1;
      for (int k = 0; k < N; k++)
         if (cid < 0 && m_pend[(m_ptr + k) % N] && m_en[(m_ptr + k) % N]) cid = (m_ptr + k) % N;
      n_ack = bus_access;
      n_err = bus_access && bus_wr_en && (bus_addr[1:0] == REG_STATUS || bus_addr[1:0] == REG_CLAIM);
      n_data = 32'h0;
      if (bus_access && !bus_wr_en) begin
         if (bus_addr[1:0] == REG_STATUS) n_data = {28'h0, m_pend};
         if (bus_addr[1:0] == REG_ENABLE) n_data = {28'h0, m_en};
         if (bus_addr[1:0] == REG_CLAIM && cid >= 0) n_data = 32'h8000_0000 | 32'(cid);
      end
      n_pend = m_pend;
      n_ptr = m_ptr;
      if (bus_access && !bus_wr_en && bus_addr[1:0] == REG_CLAIM && cid >= 0) begin
         n_pend[cid] = 1'b0;
`ifdef KEYNSHAM_IRQ_ARB_ROUND_ROBIN_EN
         n_ptr = (cid + 1) % N;
`endif
      end
      if (bus_access && bus_wr_en && bus_addr[1:0] == REG_EOI) n_pend = n_pend & ~bus_wr_val[N-1:0];
      for (int i = 0; i < N; i++)
         if (irq_src[i] && !m_prev[i]) n_pend[i] = 1'b1;
      n_en = m_en;
      if (bus_access && bus_wr_en && bus_addr[1:0] == REG_ENABLE)
         for (int i = 0; i < N; i++)
            if (bus_bytesel[i/8]) n_en[i] = bus_wr_val[i];
   end

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_pend <= '0; m_en <= '0; m_prev <= '0; m_ptr <= 0;
         m_ack <= 1'b0; m_err <= 1'b0; m_data <= 32'h0;
      end else begin
         m_pend <= n_pend; m_en <= n_en; m_prev <= irq_src; m_ptr <= n_ptr;
         m_ack <= n_ack; m_err <= n_err; m_data <= n_data;
      end
   end

   task automatic bus_op(input logic [1:0] r, input logic wr, input logic [31:0] wd, input logic [3:0] bs,
                         output logic [31:0] rd, output logic ak, output logic er);
      @(negedge clk);
      bus_access = 1'b1; bus_addr = {28'($urandom), r}; bus_wr_en = wr; bus_wr_val = wd; bus_bytesel = bs;
      @(negedge clk);
      rd = bus_data; ak = bus_ack; er = bus_error;
      bus_access = 1'b0;
   endtask

   task automatic pulse(input logic [N-1:0] m);
      @(negedge clk); irq_src = m;
      @(negedge clk); irq_src = '0;
   endtask

   task automatic test_reset();
      logic [31:0] rd; logic ak, er;
      rst = 1'b0; irq_src = 4'b1000; bus_access = 1'b0; bus_addr = '0; bus_wr_en = 1'b0;
      bus_wr_val = '0; bus_bytesel = '0;
      repeat (2) @(negedge clk);
      n_checks++; if ({irq_out, bus_ack, bus_error} !== 3'b000) begin n_fail++; $display("FAIL reset_ctrl: got %b required 000", {irq_out, bus_ack, bus_error}); end
      n_checks++; if (bus_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h required 0", bus_data); end
      rst = 1'b1;
      bus_op(REG_STATUS, 1'b0, 32'h0, 4'h0, rd, ak, er);
      n_checks++; if (rd !== 32'h8 || ak !== 1'b1) begin n_fail++; $display("FAIL reset_status: got %h ack %b required 00000008 ack 1", rd, ak); end
      n_checks++; if (irq_out !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b required 0", irq_out); end
      n_checks++; if (bus_cs !== 1'b1) begin n_fail++; $display("FAIL cs: got %b required 1", bus_cs); end
   endtask

   task automatic test_basic_claim();
      logic [31:0] rd; logic ak, er;
      @(negedge clk); irq_src = '0;
      bus_op(REG_EOI, 1'b1, 32'hF, 4'hF, rd, ak, er);
      bus_op(REG_ENABLE, 1'b1, 32'hF, 4'hF, rd, ak, er);
      pulse(4'b0100);
      n_checks++; if (irq_out !== 1'b1) begin n_fail++; $display("FAIL basic_irq_rise: got %b required 1", irq_out); end
      bus_op(REG_CLAIM, 1'b0, 32'h0, 4'h0, rd, ak, er);
      n_checks++; if (rd !== 32'h8000_0002 || er !== 1'b0) begin n_fail++; $display("FAIL basic_claim: got %h err %b required 80000002 err 0", rd, er); end
      n_checks++; if (irq_out !== 1'b0) begin n_fail++; $display("FAIL basic_irq_fall: got %b required 0", irq_out); end
      bus_op(REG_STATUS, 1'b0, 32'h0, 4'h0, rd, ak, er);
      n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL basic_status: got %h required 0", rd); end
   endtask

   task automatic test_round_robin();
      logic [31:0] rd, exp; logic ak, er;
`ifdef KEYNSHAM_IRQ_ARB_ROUND_ROBIN_EN
      int ids[3] = '{0, 1, 3};
      pulse(4'b1000);
      bus_op(REG_CLAIM, 1'b0, 32'h0, 4'h0, rd, ak, er);
      n_checks++; if (rd !== 32'h8000_0003) begin n_fail++; $display("FAIL rr_align: got %h required 80000003", rd); end
      pulse(4'b1011);
      for (int i = 0; i < 4; i++) begin
         exp = (i < 3) ? (32'h8000_0000 | 32'(ids[i])) : 32'h0;
         bus_op(REG_CLAIM, 1'b0, 32'h0, 4'h0, rd, ak, er);
         n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL rr_claim%0d: got %h required %h", i, rd, exp); end
      end
`else
      pulse(4'b1011);
      for (int i = 0; i < 3; i++) begin
         exp = 32'h8000_0000;
         bus_op(REG_CLAIM, 1'b0, 32'h0, 4'h0, rd, ak, er);
         n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL fixed_claim%0d: got %h required %h", i, rd, exp); end
         pulse(4'b0001);
      end
`endif
      bus_op(REG_EOI, 1'b1, 32'hF, 4'hF, rd, ak, er);
   endtask

   task automatic test_mask();
      logic [31:0] rd; logic ak, er;
      bus_op(REG_ENABLE, 1'b1, 32'h1, 4'hF, rd, ak, er);
      pulse(4'b0010);
      bus_op(REG_STATUS, 1'b0, 32'h0, 4'h0, rd, ak, er);
      n_checks++; if (rd !== 32'h2) begin n_fail++; $display("FAIL mask_status: got %h required 2", rd); end
      n_checks++; if (irq_out !== 1'b0) begin n_fail++; $display("FAIL mask_irq_low: got %b required 0", irq_out); end
      bus_op(REG_CLAIM, 1'b0, 32'h0, 4'h0, rd, ak, er);
      n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL mask_claim: got %h required 0", rd); end
      bus_op(REG_ENABLE, 1'b1, 32'h2, 4'hF, rd, ak, er);
      n_checks++; if (irq_out !== 1'b1) begin n_fail++; $display("FAIL mask_irq_high: got %b required 1", irq_out); end
      bus_op(REG_ENABLE, 1'b1, 32'hF, 4'h0, rd, ak, er);
      bus_op(REG_ENABLE, 1'b0, 32'h0, 4'h0, rd, ak, er);
      n_checks++; if (rd !== 32'h2) begin n_fail++; $display("FAIL mask_bytesel: got %h required 2", rd); end
   endtask

   task automatic test_collision();
      logic [31:0] rd; logic ak, er;
      bus_op(REG_EOI, 1'b1, 32'hF, 4'hF, rd, ak, er);
      @(negedge clk);
      bus_access = 1'b1; bus_addr = {28'h0, REG_EOI}; bus_wr_en = 1'b1; bus_wr_val = 32'h4; bus_bytesel = 4'hF;
      irq_src = 4'b0100;
      @(negedge clk);
      bus_access = 1'b0; irq_src = '0;
      bus_op(REG_STATUS, 1'b0, 32'h0, 4'h0, rd, ak, er);
      n_checks++; if (rd !== 32'h4) begin n_fail++; $display("FAIL collision_status: got %h required 4", rd); end
   endtask

   task automatic test_errors();
      logic [31:0] rd; logic ak, er;
      bus_op(REG_STATUS, 1'b1, 32'hFFFF, 4'hF, rd, ak, er);
      n_checks++; if ({ak, er} !== 2'b11 || rd !== 32'h0) begin n_fail++; $display("FAIL err_status_wr: got ack %b err %b data %h required 1 1 0", ak, er, rd); end
      bus_op(REG_CLAIM, 1'b1, 32'hFFFF, 4'hF, rd, ak, er);
      n_checks++; if ({ak, er} !== 2'b11) begin n_fail++; $display("FAIL err_claim_wr: got ack %b err %b required 1 1", ak, er); end
      bus_op(REG_STATUS, 1'b0, 32'h0, 4'h0, rd, ak, er);
      n_checks++; if (rd !== 32'h4 || er !== 1'b0) begin n_fail++; $display("FAIL err_status_kept: got %h err %b required 4 err 0", rd, er); end
      bus_op(REG_EOI, 1'b0, 32'h0, 4'h0, rd, ak, er);
      n_checks++; if ({ak, er} !== 2'b10 || rd !== 32'h0) begin n_fail++; $display("FAIL err_eoi_rd: got ack %b err %b data %h required 1 0 0", ak, er, rd); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd, r1, r2; logic ak, er, a1, a2;
      bus_op(REG_EOI, 1'b1, 32'hF, 4'hF, rd, ak, er);
      bus_op(REG_ENABLE, 1'b1, 32'hF, 4'hF, rd, ak, er);
      pulse(4'b0101);
      @(negedge clk);
      bus_access = 1'b1; bus_addr = {28'h0, REG_CLAIM}; bus_wr_en = 1'b0;
      @(negedge clk); r1 = bus_data; a1 = bus_ack;
      @(negedge clk); r2 = bus_data; a2 = bus_ack; bus_access = 1'b0;
      n_checks++; if (r1 !== 32'h8000_0000 || a1 !== 1'b1) begin n_fail++; $display("FAIL b2b_first: got %h ack %b required 80000000 ack 1", r1, a1); end
      n_checks++; if (r2 !== 32'h8000_0002 || a2 !== 1'b1) begin n_fail++; $display("FAIL b2b_second: got %h ack %b required 80000002 ack 1", r2, a2); end
      n_checks++; if (irq_out !== 1'b0) begin n_fail++; $display("FAIL b2b_irq: got %b required 0", irq_out); end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      bus_access = 1'b1; bus_addr = {28'h0, REG_STATUS}; bus_wr_en = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      n_checks++; if (bus_ack !== 1'b0 || bus_data !== 32'h0) begin n_fail++; $display("FAIL rst_mid_drop: got ack %b data %h required 0 0", bus_ack, bus_data); end
      bus_access = 1'b0;
      @(negedge clk); rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++; if (bus_ack !== 1'b0) begin n_fail++; $display("FAIL rst_mid_noack%0d: got %b required 0", i, bus_ack); end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         n_checks++; if (bus_ack !== m_ack || bus_error !== m_err) begin n_fail++; $display("FAIL rnd_ctrl c%0d: got ack %b err %b required %b %b", c, bus_ack, bus_error, m_ack, m_err); end
         n_checks++; if (bus_data !== m_data) begin n_fail++; $display("FAIL rnd_data c%0d: got %h required %h", c, bus_data, m_data); end
         n_checks++; if (irq_out !== |(m_pend & m_en)) begin n_fail++; $display("FAIL rnd_irq c%0d: got %b required %b", c, irq_out, |(m_pend & m_en)); end
         bus_access = ($urandom_range(0, 2) != 0);
         bus_addr = 30'($urandom);
         bus_wr_en = ($urandom_range(0, 2) == 0);
         bus_wr_val = $urandom;
         bus_bytesel = 4'($urandom);
         irq_src = ($urandom_range(0, 1) == 0) ? irq_src : 4'($urandom);
      end
      bus_access = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic_claim();
      test_round_robin();
      test_mask();
      test_collision();
      test_errors();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
